// File: rtl/bram_read_arbiter.sv
// bram_read_arbiter: arbitrates N_REQ read requesters onto a single BRAM read
// port with an optional per-requester lock, and routes each returned word back
// to the requester that issued it.
// Configuration macro: BRAM_ARB_ROUND_ROBIN_EN
//   undefined -> fixed priority (lowest index wins) while unlocked
//   defined   -> round robin starting at a rotating pointer while unlocked
module bram_read_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int N_REQ        = 3,
    parameter int READ_LATENCY = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ-1:0]            req_lock,
    output logic [N_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]       ram_addr,
    input  logic [DATA_WIDTH-1:0]       ram_dout,
    output logic [N_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]       resp_data,
    output logic                        busy
);

    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DEPTH = 1 + READ_LATENCY;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                  state_reg;
    logic [ID_W-1:0]         owner_reg;
    logic [ADDR_WIDTH-1:0]   ram_addr_reg;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]         ptr_reg;
`endif

    logic [ADDR_WIDTH-1:0]   addr_arr [N_REQ];
    logic [N_REQ-1:0]        grant_idle;
    logic                    arb_found;
    logic [N_REQ-1:0]        acc_vec;
    logic                    acc_any;
    logic [ID_W-1:0]         acc_id;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic                    acc_lock;

    logic                    pipe_valid_reg [DEPTH];
    logic [ID_W-1:0]         pipe_id_reg    [DEPTH];

    // Split the flat address bus into one slice per requester.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // Unlocked arbitration: optional pass from the pointer upward, then a
    // lowest-index pass that also serves as the wrap-around for round robin.
    always_comb begin
        grant_idle = '0;
        arb_found  = 1'b0;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < N_REQ; i++) begin
            if (!arb_found && req_valid[i] && (ID_W'(i) >= ptr_reg)) begin
                grant_idle[i] = 1'b1;
                arb_found     = 1'b1;
            end
        end
`endif
        for (int i = 0; i < N_REQ; i++) begin
            if (!arb_found && req_valid[i]) begin
                grant_idle[i] = 1'b1;
                arb_found     = 1'b1;
            end
        end
    end

    // Grant: nothing in reset, only the owner while locked, arbiter otherwise.
    always_comb begin
        req_ready = '0;
        if (!rst_in) begin
            if (state_reg == LOCKED) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (owner_reg == ID_W'(i)) begin
                        req_ready[i] = req_valid[i];
                    end
                end
            end else begin
                req_ready = grant_idle;
            end
        end
    end

    // Decode the (at most one) accepted request this cycle.
    always_comb begin
        acc_vec  = req_valid & req_ready;
        acc_any  = |acc_vec;
        acc_id   = '0;
        acc_addr = '0;
        acc_lock = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (acc_vec[i]) begin
                acc_id   = ID_W'(i);
                acc_addr = addr_arr[i];
                acc_lock = req_lock[i];
            end
        end
    end

    // Lock FSM, round-robin pointer and registered RAM address.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            ram_addr_reg <= '0;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
            ptr_reg      <= '0;
`endif
        end else if (acc_any) begin
            ram_addr_reg <= acc_addr;
            case (state_reg)
                IDLE: begin
                    if (acc_lock) begin
                        state_reg <= LOCKED;
                        owner_reg <= acc_id;
                    end
`ifdef BRAM_ARB_ROUND_ROBIN_EN
                    ptr_reg <= (acc_id == ID_W'(N_REQ - 1)) ? '0 : acc_id + 1'b1;
`endif
                end
                LOCKED: begin
                    if (!acc_lock) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // In-flight tracker: stage 0 matches ram_addr, last stage matches ram_dout.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_valid_reg[i] <= 1'b0;
                pipe_id_reg[i]    <= '0;
            end
        end else begin
            pipe_valid_reg[0] <= acc_any;
            pipe_id_reg[0]    <= acc_id;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_id_reg[i]    <= pipe_id_reg[i-1];
            end
        end
    end

    // Busy while any stage of the tracker holds a read.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy = busy | pipe_valid_reg[i];
        end
    end

    // Route the returning word to its owner.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_resp
            assign resp_valid[gi] = pipe_valid_reg[DEPTH-1] &&
                                    (pipe_id_reg[DEPTH-1] == ID_W'(gi));
        end
    endgenerate

    assign ram_addr  = ram_addr_reg;
    assign resp_data = ram_dout;

endmodule
